gene_tx_scheduler: RTL and testbench

- Shares the single 9600-baud UART gene sender (240-bit genome, 30 bytes per frame) between NUM_REQ genome producers, e.g. population slots.
- Arbitrates round-robin and latches the winner's genome into a holding register, so the sender's data input stays stable for the whole frame.
- Issues a one-cycle start, waits for the sender's one-cycle done, acks the requester, then enforces an idle gap before the next frame.
- A watchdog aborts a frame whose done never arrives.

---
 rtl/gene_tx_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/gene_tx_scheduler.sv | 116 +++++++++++
 tb/tb_gene_tx_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gene_tx_pkg.sv
// Shared definitions for the gene sender scheduler: controller states and
// UART gene-frame constants.
package gene_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int GENE_W     = 240;
  localparam int GENE_BYTES = GENE_W / 8;
  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 9600;

  // Rounded up so the inter-frame gap is never shorter than one bit time.
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud - 1) / baud;
  endfunction

  localparam int BIT_CYCLES = cycles_per_bit(CLK_HZ, BAUD);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request after ptr
// (wrapping modulo N) wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] winner
);

  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [IW:0] sum;

  // Scan from the farthest offset down so the closest requester after ptr is
  // the last one written and therefore wins.
  always_comb begin
    valid  = 1'b0;
    winner = ptr;
    sum    = '0;
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= NV) sum = sum - NV;
      if (req[sum[IW-1:0]]) begin
        valid  = 1'b1;
        winner = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gene_tx_scheduler.sv
// Shares one UART gene sender between NUM_REQ producers: round-robin grant,
// genome latch, start/done handshake, watchdog abort and inter-frame gap.
module gene_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GENE_W         = gene_tx_pkg::GENE_W,
  parameter int GAP_CYCLES     = gene_tx_pkg::BIT_CYCLES,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*GENE_W-1:0] genome,
  output logic [NUM_REQ-1:0]        ack,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic [GENE_W-1:0]         tx_in,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      timeout_err,
  output logic [15:0]               frames_sent
);

  import gene_tx_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic [GC_W-1:0]   gap_cnt;
  logic              arb_valid;
  logic [IW-1:0]     arb_winner;
  logic [GENE_W-1:0] slot [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot[gi] = genome[gi*GENE_W +: GENE_W];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      tx_in       <= '0;
      tx_start    <= 1'b0;
      ack         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frames_sent <= '0;
    end else begin
      tx_start    <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && arb_valid) begin
            tx_in    <= slot[arb_winner];
            grant_id <= arb_winner;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // Done is checked first so a done on the watchdog's last cycle
          // still completes the frame normally.
          if (tx_done) begin
            ack[grant_id] <= 1'b1;
            if (frames_sent != 16'hFFFF) frames_sent <= frames_sent + 1'b1;
            ptr     <= grant_id;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            ptr         <= grant_id;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gene_tx_scheduler.sv
// Directed bench for gene_tx_scheduler with a sender model that answers
// every start with a done pulse 20 cycles later.
module tb_gene_tx_scheduler;

  localparam int NR = 4;
  localparam int GW = 240;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic [NR-1:0]    req;
  logic [NR*GW-1:0] genome;
  logic [NR-1:0]    ack;
  logic [1:0]       grant_id;
  logic             busy;
  logic [GW-1:0]    tx_in;
  logic             tx_start;
  logic             tx_done;
  logic             timeout_err;
  logic [15:0]      frames_sent;

  gene_tx_scheduler #(
    .NUM_REQ(NR), .GENE_W(GW), .GAP_CYCLES(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .genome(genome),
    .ack(ack), .grant_id(grant_id), .busy(busy), .tx_in(tx_in),
    .tx_start(tx_start), .tx_done(tx_done), .timeout_err(timeout_err),
    .frames_sent(frames_sent)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Sender model: done is high for the cycle that ends 20 edges after start.
  logic model_en, model_done, manual_done;
  int   cd;
  assign tx_done = model_done | manual_done;
  always @(negedge clk) begin
    if (!model_en) begin
      cd = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (tx_start) cd = 20;
      else if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) model_done = 1'b1;
      end
    end
  end

  logic [7:0] slot_byte [NR];

  function automatic logic [GW-1:0] pat(input logic [7:0] b);
    return {30{b}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_start) begin ok = 1; break; end
    end
    chk("start_seen", ok, 1);
  endtask

  task automatic wait_ack(input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack != '0) begin ok = 1; break; end
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic wait_idle(input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("idle_seen", ok, 1);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  grant;
    logic [3:0]  ack;
    logic [15:0] frames;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ok, s, prev_s, sep;
    logic seen;

    vecs[0] = '{4'b1111, 2'd0, 4'b0001, 16'd1};
    vecs[1] = '{4'b1111, 2'd1, 4'b0010, 16'd2};
    vecs[2] = '{4'b1111, 2'd2, 4'b0100, 16'd3};
    vecs[3] = '{4'b1111, 2'd3, 4'b1000, 16'd4};
    vecs[4] = '{4'b1111, 2'd0, 4'b0001, 16'd5};
    vecs[5] = '{4'b0100, 2'd2, 4'b0100, 16'd6};
    vecs[6] = '{4'b0011, 2'd0, 4'b0001, 16'd7};
    vecs[7] = '{4'b1010, 2'd1, 4'b0010, 16'd8};
    vecs[8] = '{4'b1001, 2'd3, 4'b1000, 16'd9};

    slot_byte[0] = 8'h3C; slot_byte[1] = 8'h5A;
    slot_byte[2] = 8'hA5; slot_byte[3] = 8'hC3;
    for (int i = 0; i < NR; i++) genome[i*GW +: GW] = pat(slot_byte[i]);

    reset_n = 1'b0; enable = 1'b1; req = '0; manual_done = 1'b0; model_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {tx_start, busy, ack, grant_id, timeout_err, frames_sent}, '0);
    chk("reset_tx_in", tx_in, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // tx_done while idle must be ignored.
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    chk("idle_done_ack", ack, 0);
    chk("idle_done_state", {busy, frames_sent}, 0);
    $display("txn idle_done: ack=%b frames=%0d", ack, frames_sent);

    // Single request: start in the cycle after the arbitration edge.
    req = 4'b0100;
    @(negedge clk);
    chk("single_start", tx_start, 1);
    chk("single_grant", grant_id, 2);
    chk("single_tx_in", tx_in, pat(8'hA5));
    s = cyc;
    @(negedge clk);
    chk("single_start_pulse", tx_start, 0);
    wait_ack(40, ok);
    req = '0;
    chk("single_ack", ack, 4'b0100);
    chk("single_ack_lat", cyc - s, 21);
    chk("single_frames", frames_sent, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) chk("single_ack_pulse", ack, 0);
      if (i == 7) chk("single_busy_gap", busy, 1);
      if (i == 8) chk("single_busy_end", busy, 0);
    end
    $display("txn single: grant=2 ack=0100 frames=%0d", frames_sent);

    // enable low blocks grants; raising it grants requester 0 (ptr is 2).
    enable = 1'b0;
    req = 4'b0011;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | tx_start | busy;
    end
    chk("enable_hold", seen, 0);
    enable = 1'b1;
    wait_start(2, ok);
    chk("enable_grant", grant_id, 0);
    wait_ack(40, ok);
    req = '0;
    chk("enable_ack", ack, 4'b0001);
    chk("enable_frames", frames_sent, 2);
    wait_idle(20, ok);
    $display("txn enable: grant=0 frames=%0d", frames_sent);

    // Asynchronous reset in the middle of WAIT.
    req = 4'b0010;
    wait_start(3, ok);
    chk("rst_pre_grant", grant_id, 1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    model_en = 1'b0;
    #1;
    chk("rst_async_ctrl", {tx_start, busy, ack, grant_id, timeout_err, frames_sent}, '0);
    chk("rst_async_tx_in", tx_in, '0);
    @(negedge clk);
    reset_n = 1'b1;
    model_en = 1'b1;
    $display("txn reset_mid_wait: busy=%0d frames=%0d", busy, frames_sent);

    // Table: round-robin after reset, then mixed patterns.
    prev_s = 0;
    for (int i = 0; i < 9; i++) begin
      req = vecs[i].req;
      wait_start(40, ok);
      s = cyc;
      chk("tbl_grant", grant_id, vecs[i].grant);
      chk("tbl_tx_in", tx_in, pat(slot_byte[vecs[i].grant]));
      if (i > 0) begin
        sep = s - prev_s;
        chk("tbl_sep", (sep >= 30), 1);
      end
      prev_s = s;
      wait_ack(40, ok);
      chk("tbl_ack", ack, vecs[i].ack);
      chk("tbl_frames", frames_sent, vecs[i].frames);
      @(negedge clk);
      chk("tbl_ack_pulse", ack, 0);
      wait_idle(20, ok);
      $display("txn tbl%0d: req=%b grant=%0d frames=%0d", i, vecs[i].req, vecs[i].grant, frames_sent);
    end

    // Genome change and req drop mid-WAIT (ptr is 3, so 2 wins).
    req = 4'b0100;
    wait_start(3, ok);
    chk("stab_grant", grant_id, 2);
    repeat (4) @(negedge clk);
    genome[2*GW +: GW] = pat(8'h0F);
    req = '0;
    wait_ack(40, ok);
    chk("stab_ack", ack, 4'b0100);
    chk("stab_tx_in", tx_in, pat(8'hA5));
    chk("stab_frames", frames_sent, 10);
    genome[2*GW +: GW] = pat(8'hA5);
    wait_idle(20, ok);
    $display("txn stability: ack=0100 frames=%0d", frames_sent);

    // Watchdog: sender silent, requester 0 aborted, then 1, then 0 again.
    model_en = 1'b0;
    req = 4'b0011;
    wait_start(3, ok);
    chk("to_grant", grant_id, 0);
    seen = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      seen = seen | timeout_err | (ack != '0);
    end
    chk("to_early", seen, 0);
    @(negedge clk);
    chk("to_pulse", timeout_err, 1);
    chk("to_no_ack", ack, 0);
    @(negedge clk);
    chk("to_pulse_end", timeout_err, 0);
    chk("to_frames", frames_sent, 10);
    model_en = 1'b1;
    wait_idle(20, ok);
    $display("txn timeout: grant=0 frames=%0d", frames_sent);
    wait_start(3, ok);
    chk("to_next_grant", grant_id, 1);
    wait_ack(40, ok);
    chk("to_next_ack", ack, 4'b0010);
    req = 4'b0001;
    wait_idle(20, ok);
    wait_start(3, ok);
    chk("to_regrant", grant_id, 0);
    wait_ack(40, ok);
    chk("to_regrant_ack", ack, 4'b0001);
    chk("to_regrant_frames", frames_sent, 12);
    wait_idle(20, ok);
    $display("txn retry: grant=0 frames=%0d", frames_sent);

    // Saturation of the frame counter.
    @(negedge clk);
    force dut.frames_sent = 16'hFFFE;
    @(negedge clk);
    release dut.frames_sent;
    for (int i = 0; i < 3; i++) begin
      wait_start(40, ok);
      wait_ack(40, ok);
      chk("sat_frames", frames_sent, 16'hFFFF);
      $display("txn sat%0d: frames=%h", i, frames_sent);
    end
    req = '0;
    wait_idle(20, ok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
